// File: rtl/fsm_binary_decoder.sv
// fsm_binary_decoder: tracks the 4-state one-hot Mealy encoder from its serial
// output, recovers the original bits and packs them into DATA_W-bit words on a
// valid/ready port. Define FSMDEC_STATUS_EN to add dec_state/overrun outputs.
module fsm_binary_decoder #(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    input  logic              sync,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef FSMDEC_STATUS_EN
    ,
    output logic [3:0]        dec_state,
    output logic              overrun
`endif
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [3:0] {
        S0 = 4'b0001,
        S1 = 4'b0010,
        S2 = 4'b0100,
        S3 = 4'b1000
    } state_t;

    state_t            st, nxt;
    logic [CW-1:0]     cnt, pos;
    logic [DATA_W-1:0] sh, word;
    logic              last, acc, d;

    assign last     = cnt == CW'(DATA_W - 1);
    assign in_ready = !sync && (!last || !out_valid || out_ready);
    assign acc      = in_valid && in_ready;
    assign d        = in_bit ^ (st == S1);
    assign pos      = LSB_FIRST ? cnt : CW'(DATA_W - 1) - cnt;

    // decoded bit merged into the partial word and tracker successor state
    always_comb begin
        word      = sh;
        word[pos] = d;
        nxt       = st == S0 ? (d ? S1 : S0) :
                    st == S1 ? (d ? S3 : S2) :
                    st == S2 ? (d ? S3 : S0) :
                    st == S3 ? (d ? S0 : S3) : S0;
    end

    // tracker, packer and output register; sync outranks bit acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= S0;
            cnt       <= '0;
            sh        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef FSMDEC_STATUS_EN
            overrun   <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (sync) begin
                st  <= S0;
                cnt <= '0;
                sh  <= '0;
            end else if (acc) begin
                st <= nxt;
                if (last) begin
                    cnt       <= '0;
                    sh        <= '0;
                    out_data  <= word;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                    sh  <= word;
                end
            end
`ifdef FSMDEC_STATUS_EN
            if (in_valid && !in_ready && !sync)
                overrun <= 1'b1;
`endif
        end
    end

`ifdef FSMDEC_STATUS_EN
    assign dec_state = st;
`endif
endmodule

// File: tb/tb_fsm_binary_decoder.sv
// tb_fsm_binary_decoder: encodes random and directed words with a behavioural
// encoder, streams them into an LSB-first and an MSB-first decoder, and checks
// the recovered words against a scoreboard.
module tb_fsm_binary_decoder;
    logic       clk = 0;
    logic       reset_n = 0;
    logic       in_valid = 0, in_bit = 0, sync = 0, out_ready = 1;
    logic       in_ready, out_valid, in_ready1, out_valid1;
    logic [7:0] out_data, out_data1;
`ifdef FSMDEC_STATUS_EN
    logic [3:0] dec_state, dec_state1;
    logic       overrun, overrun1;
`endif

    int         checks = 0, errors = 0;
    int         s = 0;
    int         nt [4][2] = '{'{0, 1}, '{2, 3}, '{0, 3}, '{3, 0}};
    logic [7:0] q [$];
    bit         rnd_en = 0;
    bit         held = 0;
    logic [7:0] held_data;

    fsm_binary_decoder #(.DATA_W(8), .LSB_FIRST(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .sync(sync), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready)
`ifdef FSMDEC_STATUS_EN
        , .dec_state(dec_state), .overrun(overrun)
`endif
    );

    fsm_binary_decoder #(.DATA_W(8), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready1), .sync(sync), .out_valid(out_valid1),
        .out_data(out_data1), .out_ready(out_ready)
`ifdef FSMDEC_STATUS_EN
        , .dec_state(dec_state1), .overrun(overrun1)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) rev8[i] = w[7-i];
    endfunction

    // scoreboard: every drained word must be the next word the encoder was fed
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got %h want none", out_data);
            end else begin
                if (out_data !== q[0] || out_data1 !== rev8(q[0]) || out_valid1 !== 1'b1) begin
                    errors++;
                    $display("FAIL sb_word got %h/%h want %h/%h", out_data, out_data1, q[0], rev8(q[0]));
                end
                void'(q.pop_front());
            end
        end
        if (reset_n && out_valid && !out_ready) begin
            if (held) begin
                checks++;
                if (out_data !== held_data) begin
                    errors++;
                    $display("FAIL stall_stable got %h want %h", out_data, held_data);
                end
            end
            held = 1;
            held_data = out_data;
        end else held = 0;
    end

    always @(posedge clk) if (rnd_en) begin #1; out_ready = 1'($urandom_range(1)); end

    task automatic send_bit(input logic e);
        int n = 0;
        in_valid = 1;
        in_bit = e;
        @(negedge clk);
        while (!in_ready && n < 100) begin n++; @(negedge clk); end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic send_enc(input logic d, input bit gaps);
        logic e;
        e = d ^ (s == 1);
        s = nt[s][d];
        send_bit(e);
`ifdef FSMDEC_STATUS_EN
        checks++;
        if (dec_state !== 4'(1 << s)) begin
            errors++;
            $display("FAIL dec_state got %b want %b", dec_state, 4'(1 << s));
        end
`endif
        if (gaps && $urandom_range(3) == 0) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [7:0] w, input bit gaps);
        q.push_back(w);
        for (int i = 0; i < 8; i++) send_enc(w[i], gaps);
    endtask

    task automatic do_reset();
        reset_n = 0;
        s = 0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    task automatic test_reset();
        in_valid = 0; sync = 0; out_ready = 1;
        reset_n = 0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_valid1 !== 1'b0 || out_data1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got %b/%h want 0/00", out_valid, out_data);
        end
        do_reset();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
`ifdef FSMDEC_STATUS_EN
        checks++;
        if (dec_state !== 4'b0001 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got %b/%b want 0001/0", dec_state, overrun);
        end
`endif
    endtask

    task automatic test_basic();
        logic [7:0] enc = 8'b1011_1101;
        logic [3:0] exp_st [8] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
        q.push_back(8'hAF);
        for (int i = 0; i < 8; i++) begin
            send_bit(enc[i]);
`ifdef FSMDEC_STATUS_EN
            checks++;
            if (dec_state !== exp_st[i]) begin
                errors++;
                $display("FAIL basic_state%0d got %b want %b", i, dec_state, exp_st[i]);
            end
`endif
            if (i < 7) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_valid bit %0d got %b want 0", i, out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hAF || out_data1 !== 8'hF5) begin
            errors++;
            $display("FAIL basic_word got %b/%h/%h want 1/af/f5", out_valid, out_data, out_data1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hAF) begin
            errors++;
            $display("FAIL basic_pulse got %b/%h want 0/af", out_valid, out_data);
        end
    endtask

    task automatic test_zeros();
        do_reset();
        send_word(8'h00, 0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || s != 0) begin
            errors++;
            $display("FAIL zeros got %b/%h want 1/00", out_valid, out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [7:0] w2 = 8'($urandom);
        logic       e;
        out_ready = 0;
        send_word(8'hAF, 0);
        q.push_back(w2);
        for (int i = 0; i < 7; i++) send_enc(w2[i], 0);
        e = w2[7] ^ (s == 1);
        s = nt[s][w2[7]];
        in_valid = 1;
        in_bit = e;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready got %b want 0", in_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hAF) begin
            errors++;
            $display("FAIL bp_hold got %b/%h want 1/af", out_valid, out_data);
        end
`ifdef FSMDEC_STATUS_EN
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_overrun got %b want 1", overrun);
        end
`endif
        @(posedge clk);
        #1;
        out_ready = 1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== w2) begin
            errors++;
            $display("FAIL bp_reload got %b/%h want 1/%h", out_valid, out_data, w2);
        end
        @(posedge clk);
        #1;
`ifdef FSMDEC_STATUS_EN
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_overrun_sticky got %b want 1", overrun);
        end
`endif
    endtask

    task automatic test_sync();
        out_ready = 1;
        for (int i = 0; i < 3; i++) send_enc(1'($urandom_range(1)), 0);
        in_valid = 1;
        in_bit = 1'($urandom_range(1));
        sync = 1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL sync_in_ready got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        sync = 0;
        in_valid = 0;
        s = 0;
        send_word(8'hAF, 0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hAF) begin
            errors++;
            $display("FAIL sync_word got %b/%h want 1/af", out_valid, out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        send_word(8'($urandom), 0);
        for (int i = 0; i < 5; i++) send_enc(1'($urandom_range(1)), 0);
        @(negedge clk);
        #2;
        reset_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got %b/%h want 0/00", out_valid, out_data);
        end
`ifdef FSMDEC_STATUS_EN
        checks++;
        if (overrun !== 1'b0 || dec_state !== 4'b0001) begin
            errors++;
            $display("FAIL async_status got %b/%b want 0/0001", overrun, dec_state);
        end
`endif
        q.delete();
        s = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
        out_ready = 1;
        send_word(8'hAF, 0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hAF) begin
            errors++;
            $display("FAIL async_after got %b/%h want 1/af", out_valid, out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int n = 0;
        rnd_en = 1;
        for (int i = 0; i < 40; i++) send_word(8'($urandom), 1);
        rnd_en = 0;
        @(posedge clk);
        #2;
        out_ready = 1;
        while (q.size() != 0 && n < 50) begin @(posedge clk); n++; end
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL random_drain got %0d left want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zeros();
        test_backpressure();
        test_sync();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fsm_binary_decoder.md
Name: fsm_binary_decoder

Overview:
Receive-side inverse of the team's 4-state Mealy bit-stream encoder (one-hot S0=0001, S1=0010, S2=0100, S3=1000). The block tracks the encoder state from the encoded serial bits, recovers the original bits, and packs them into DATA_W-bit words. Words are presented on a valid/ready output port. It sits between the serial link sampler and the word-level consumer.

Parameters:
DATA_W, 8, output word width in bits; legal range 2..32
LSB_FIRST, 1, 1 = first recovered bit lands in out_data[0]; 0 = first bit lands in out_data[DATA_W-1]

Ports:
clk  input  1  single clock; all logic on the rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_bit is valid this cycle
in_bit  input  1  encoded serial bit
in_ready  output  1  decoder accepts in_bit this cycle
sync  input  1  resynchronise: tracker to S0, discard partial word
out_valid  output  1  out_data holds a complete word
out_data  output  DATA_W  recovered word
out_ready  input  1  consumer takes the word this cycle

Behaviour:
- Reset (reset_n=0, asynchronous):
  - tracker state = S0 (0001)
  - bit count = 0; shift register = 0
  - out_valid = 0; out_data = 0
- Bit transfer: accepted when in_valid && in_ready, sampled at the rising edge.
- Decode rule for accepted bit e in state s: d = e XOR (s==S1).
- Tracker next state, using decoded bit d:
  - S0: d=1 → S1; d=0 → S0
  - S1: d=1 → S3; d=0 → S2
  - S2: d=1 → S3; d=0 → S0
  - S3: d=1 → S0; d=0 → S3
  - Non-one-hot state: treat as S0 (d=e, next S0).
- Packing:
  - Each accepted d is placed at position = bit count (LSB_FIRST=1) or DATA_W-1-bit count (LSB_FIRST=0).
  - Bit count increments per accepted bit.
  - The DATA_W-th accepted bit completes the word. On that edge the full word (including this bit) loads into out_data, out_valid goes 1, bit count returns to 0, and the shift register clears.
  - Latency: out_valid rises on the clock edge that accepts the last bit; it is visible in the following cycle.
- in_ready = !sync && (bit count != DATA_W-1 || !out_valid || out_ready).
  - Bits 1..DATA_W-1 are always accepted, even while a word is waiting.
  - The completing bit is accepted only if the output register is empty or being drained in the same cycle. This gives zero-bubble streaming.
- Output handshake:
  - out_valid && out_ready drains the word; out_valid goes 0 unless a new word loads on the same edge (then it stays 1 with the new data).
  - out_data is stable while out_valid && !out_ready.
  - out_data holds its last value after draining.
- sync=1: tracker to S0, bit count and shift register to 0, in_ready=0 (no bit consumed). out_valid and out_data are unaffected; a pending word can still drain. sync has priority over bit acceptance.
- Reset asserted mid-word or mid-handshake: all state returns to reset values immediately; the partial word and the pending word are lost.

Optional Feature:
FSMDEC_STATUS_EN
- Defined: adds output dec_state[3:0] (current tracker state, one-hot) and output overrun (1 bit, sticky). overrun sets when in_valid=1 is held with in_ready=0 for the completing bit while sync=0. It clears only on reset.
- Undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
1. Reset, DATA_W=8, LSB_FIRST=1, out_ready=1; feed encoded 1,0,1,1,1,1,0,1 back-to-back → one out_valid pulse with out_data=0xAF one cycle after the 8th bit; tracker ends in S0.
2. Eight encoded 0s from reset → out_data=0x00, tracker stays S0; LSB_FIRST=0 build with the sequence from scenario 1 → out_data=0xF5.
3. Backpressure: out_ready=0 after the first word (0xAF); stream the next word → 7 bits accepted, in_ready=0 on the 8th; out_data stays 0xAF. Raise out_ready → 0xAF drains and the new word loads on the same edge, with no idle cycle.
4. Sync mid-word: 3 arbitrary encoded bits, then sync=1 for 1 cycle (in_ready=0), then encoded 1,0,1,1,1,1,0,1 → out_data=0xAF.
5. Drop reset_n asynchronously between clock edges after 5 bits with a pending word → out_valid=0 and out_data=0 immediately; after release, scenario 1 stream → 0xAF.
6. FSMDEC_STATUS_EN build: dec_state follows 0001,0010,1000,0001,0010,0100,1000,1000,0001 over scenario 1. overrun sets during the scenario 3 stall and persists until reset.
